// File: rtl/gate_test_sequencer.sv
// Steps a 2-input gate through minterms 00..11, holding each for SETTLE+1 cycles, and compares s_in with a latched truth table.
// done rises 4*(SETTLE+1) cycles after an accepted start; start is ignored while busy, and there is no other backpressure.
module gate_test_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] m_q, m_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] xy_q, xy_d;
  logic [3:0] exp_q, exp_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      xy_q    <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      xy_q    <= xy_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    xy_d    = xy_q;
    exp_d   = exp_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Results of the previous run stay visible until a new run is accepted.
        if (start) begin
          m_d     = '0;
          cnt_d   = '0;
          xy_d    = '0;
          exp_d   = expected;
          err_d   = '0;
          fail_d  = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (s_in != exp_q[m_q]) begin
          err_d        = err_q + 3'd1;
          fail_d[m_q]  = 1'b1;
        end
        // The last minterm leaves {x,y} at 11 while results are held.
        if (m_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          m_d     = m_q + 2'd1;
          xy_d    = m_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign x         = xy_q[1];
  assign y         = xy_q[0];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: two instances (SETTLE=1 and SETTLE=3) driven from vector tables plus hand sequences.
module tb_gate_test_sequencer;

  typedef struct {
    logic [3:0] exp;
    int         model;
    logic [3:0] mask;
    logic [2:0] err;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] err;
    logic       pass;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_w;
  logic [3:0] exp_w [2];
  logic [1:0] s_w;
  logic [1:0] x_w;
  logic [1:0] y_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] pass_w;
  logic [2:0] err_w [2];
  logic [3:0] mask_w [2];
  int         mdl [2];

  int n_pass;
  int n_total;
  res_t sb_q[$];

  vec_t tbl0 [8];
  vec_t tbl1 [3];

  // Models: 0 = x|~y, 1 = stuck at 0, 2 = x&y, 3 = stuck at 1.
  function automatic logic gate(input int md, input logic a, input logic b);
    case (md)
      0:       return a | ~b;
      1:       return 1'b0;
      2:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  assign s_w[0] = gate(mdl[0], x_w[0], y_w[0]);
  assign s_w[1] = gate(mdl[1], x_w[1], y_w[1]);

  gate_test_sequencer #(.SETTLE(1)) dut_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_w[0]),
    .expected  (exp_w[0]),
    .s_in      (s_w[0]),
    .x         (x_w[0]),
    .y         (y_w[0]),
    .busy      (busy_w[0]),
    .done      (done_w[0]),
    .pass      (pass_w[0]),
    .err_count (err_w[0]),
    .fail_mask (mask_w[0])
  );

  gate_test_sequencer #(.SETTLE(3)) dut_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_w[1]),
    .expected  (exp_w[1]),
    .s_in      (s_w[1]),
    .x         (x_w[1]),
    .y         (y_w[1]),
    .busy      (busy_w[1]),
    .done      (done_w[1]),
    .pass      (pass_w[1]),
    .err_count (err_w[1]),
    .fail_mask (mask_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs(input int d);
    return {x_w[d], y_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], mask_w[d]};
  endfunction

  task automatic run_vec(input int d, input vec_t v, input int restart_at,
                         input int chg_at, input logic [3:0] chg_val, input string tag);
    int   s;
    int   lat;
    bit   seq_bad;
    res_t r;
    res_t want;
    s = (d == 0) ? 1 : 3;
    mdl[d]   = v.model;
    exp_w[d] = v.exp;
    @(negedge clk);
    start_w[d] = 1'b1;
    want.mask = v.mask;
    want.err  = v.err;
    want.pass = v.pass;
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    start_w[d] = 1'b0;
    lat     = -1;
    seq_bad = 1'b0;
    for (int k = 0; k < 4 * (s + 1) + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done_w[d]) begin
        lat = k;
        break;
      end
      if (busy_w[d] !== 1'b1 || {x_w[d], y_w[d]} !== 2'(k / (s + 1))) seq_bad = 1'b1;
      start_w[d] = (k == restart_at);
      if (k == chg_at) exp_w[d] = chg_val;
    end
    start_w[d] = 1'b0;
    check({tag, ".latency"}, lat, 4 * (s + 1));
    check({tag, ".xy_seq"}, int'(seq_bad), 0);
    check({tag, ".xy_done"}, int'({x_w[d], y_w[d]}), 3);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 0, 1);
    end else begin
      r = sb_q.pop_front();
      check({tag, ".fail_mask"}, int'(mask_w[d]), int'(r.mask));
      check({tag, ".err_count"}, int'(err_w[d]), int'(r.err));
      check({tag, ".pass"}, int'(pass_w[d]), int'(r.pass));
      check({tag, ".popcount"}, int'(err_w[d]), $countones(mask_w[d]));
      mdl[d]   = 3 - v.model;
      exp_w[d] = ~v.exp;
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".hold"}, int'({done_w[d], busy_w[d], pass_w[d], err_w[d], mask_w[d]}),
            int'({1'b1, 1'b0, r.pass, r.err, r.mask}));
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start_w = '0;
    exp_w[0] = '0;
    exp_w[1] = '0;
    mdl[0]  = 0;
    mdl[1]  = 0;

    tbl0[0] = '{4'b1101, 0, 4'b0000, 3'd0, 1'b1};
    tbl0[1] = '{4'b1101, 1, 4'b1101, 3'd3, 1'b0};
    tbl0[2] = '{4'b1000, 2, 4'b0000, 3'd0, 1'b1};
    tbl0[3] = '{4'b0000, 0, 4'b1101, 3'd3, 1'b0};
    tbl0[4] = '{4'b1111, 2, 4'b0111, 3'd3, 1'b0};
    tbl0[5] = '{4'b0110, 1, 4'b0110, 3'd2, 1'b0};
    tbl0[6] = '{4'b0001, 0, 4'b1100, 3'd2, 1'b0};
    tbl0[7] = '{4'b0000, 3, 4'b1111, 3'd4, 1'b0};
    tbl1[0] = '{4'b1000, 2, 4'b0000, 3'd0, 1'b1};
    tbl1[1] = '{4'b1101, 1, 4'b1101, 3'd3, 1'b0};
    tbl1[2] = '{4'b0110, 3, 4'b1001, 3'd2, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset.outs_s1", outs(0), 0);
    check("reset.outs_s3", outs(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_reset.s1", outs(0), 0);
    check("idle_after_reset.s3", outs(1), 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(0, tbl0[i], -1, -1, 4'b0000, $sformatf("s1_vec%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      run_vec(1, tbl1[i], -1, -1, 4'b0000, $sformatf("s3_vec%0d", i));
    end

    run_vec(0, tbl0[1], 3, -1, 4'b0000, "restart_ignored");

    run_vec(0, tbl0[0], -1, 1, 4'b0000, "exp_latched");
    run_vec(0, tbl0[3], -1, -1, 4'b0000, "rerun_from_done");

    // Abort a run in the CHECK cycle of minterm 2 (state after edge 5).
    mdl[0]   = 0;
    exp_w[0] = 4'b1101;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid.pre_xy", int'({x_w[0], y_w[0]}), 2);
    check("rst_mid.pre_busy", int'(busy_w[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid.outs", outs(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.stays_idle", outs(0), 0);
    run_vec(0, tbl0[0], -1, -1, 4'b0000, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles the inputs are held before the output is sampled (legal range 1..15).
REQ-002 Port: clk  input  1  single clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  single-cycle run request, sampled when not busy.
REQ-005 Port: expected  input  4  truth table under test; bit m is the expected output for minterm m={x,y}; latched on accepted start.
REQ-006 Port: s_in  input  1  output of the 2-input gate under test.
REQ-007 Port: x  output  1  first gate input, registered, equal to minterm bit 1.
REQ-008 Port: y  output  1  second gate input, registered, equal to minterm bit 0.
REQ-009 Port: busy  output  1  high from accepted start until the run completes.
REQ-010 Port: done  output  1  high while the results of the last run are valid.
REQ-011 Port: pass  output  1  high only when done=1 and err_count=0.
REQ-012 Port: err_count  output  3  number of mismatching minterms in the last run, 0..4.
REQ-013 Port: fail_mask  output  4  bit m set when minterm m mismatched.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE, plus a 2-bit minterm register m and a 4-bit settle counter cnt.
REQ-015 In IDLE or DONE, start=1 SHALL perform the following at that edge: m=0, {x,y}=00, cnt=0, err_count=0, fail_mask=0, latch expected, and go to SETTLE; done and pass SHALL then read 0.
REQ-016 In SETTLE, cnt SHALL increment each cycle; at the edge where cnt==SETTLE-1 the FSM SHALL go to CHECK.
REQ-017 In CHECK (exactly one cycle), s_in SHALL be compared with latched expected[m]; on a mismatch, err_count increments and fail_mask[m] is set at that edge.
REQ-018 In CHECK with m<3, the FSM SHALL set m=m+1, set {x,y}=m+1 and cnt=0, and return to SETTLE.
REQ-019 In CHECK with m==3, the FSM SHALL go to DONE, and {x,y} SHALL hold 11.
REQ-020 busy SHALL be 1 in SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 only in DONE; err_count, fail_mask and pass SHALL hold stable in DONE until the next accepted start.
REQ-022 Latency: done SHALL rise exactly 4*(SETTLE+1) cycles after the edge that accepts start (8 cycles for SETTLE=1).
REQ-023 start asserted in SETTLE or CHECK SHALL be ignored, with no restart and no state change.
REQ-024 x and y SHALL change only on the edge entering SETTLE, so each minterm is held stable for SETTLE+1 cycles, including the CHECK cycle.
REQ-025 Changes to the expected input after start is accepted SHALL NOT affect the current run.
REQ-026 err_count SHALL equal the popcount of fail_mask at all times.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, m=0, cnt=0, x=0, y=0, busy=0, done=0, pass=0, err_count=0 and fail_mask=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no partial results retained.
REQ-029 After rst_n deasserts, the block SHALL take no action until start is sampled high.

Verification
REQ-030 SETTLE=1, expected=4'b1101, s_in driven by the model s=x|~y, one start pulse -> {x,y} steps through 00,01,10,11, each held 2 cycles; done=1 at cycle 8; pass=1; err_count=0; fail_mask=0000.
REQ-031 SETTLE=1, expected=4'b1101, s_in stuck at 0 -> done at cycle 8; pass=0; err_count=3; fail_mask=1101.
REQ-032 SETTLE=3, expected=4'b1000, correct AND model -> done exactly 16 cycles after start; pass=1; each minterm held 4 cycles.
REQ-033 start pulsed again at cycle 3 of a run -> ignored; done still at cycle 8; the results match a single run.
REQ-034 rst_n pulsed low during CHECK of minterm 2 -> all outputs 0 immediately; FSM in IDLE; a new start produces a complete, correct run.
REQ-035 expected changed from 1101 to 0000 one cycle after start, with a correct x|~y model -> pass=1, confirming the latched copy is used; a second start in DONE clears done the next cycle and reruns with 0000, giving err_count=3.
